// File: rtl/init_done_reset_sequencer.sv
// Fabric reset sequencer: waits for POR, init-done and filtered PLL lock, then releases a stretched reset.
// Define INIT_SEQ_SRAM_GATE_EN to also require SRAM_INIT_DONE and USRAM_INIT_DONE before leaving WAIT_INIT.
//
// state     | meaning
// WAIT_POR  | holding until the init monitor releases FABRIC_POR_N
// WAIT_INIT | waiting for init_ok, timeout running
// WAIT_LOCK | filtering PLL lock, timeout still running
// STRETCH   | all conditions met, holding fabric reset for RELEASE_DELAY cycles
// RUN       | fabric reset released
// ERROR     | init or lock never arrived; sticky until EXT_RST_N
module init_done_reset_sequencer #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned LOCK_FILTER    = 16,
   parameter int unsigned RELEASE_DELAY  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic       CLK,
   input  logic       EXT_RST_N,
   input  logic       FABRIC_POR_N,
   input  logic       DEVICE_INIT_DONE,
   input  logic       SRAM_INIT_DONE,
   input  logic       USRAM_INIT_DONE,
   input  logic       PLL_LOCK,
   output logic       FABRIC_RESET_N,
   output logic [2:0] INIT_STATE,
   output logic       TIMEOUT_ERR
);

   localparam int LCK_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam int REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_FILTER - 1);
   localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DELAY - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_POR  = 3'd0,
      WAIT_INIT = 3'd1,
      WAIT_LOCK = 3'd2,
      STRETCH   = 3'd3,
      RUN       = 3'd4,
      ERROR     = 3'd5
   } state_t;

`ifdef INIT_SEQ_SRAM_GATE_EN
   localparam int NS = 5;
   logic [NS-1:0] async_in;
   assign async_in = {USRAM_INIT_DONE, SRAM_INIT_DONE, PLL_LOCK, DEVICE_INIT_DONE, FABRIC_POR_N};
`else
   localparam int NS = 3;
   logic [NS-1:0] async_in;
   logic          unused_sram_done;
   assign async_in         = {PLL_LOCK, DEVICE_INIT_DONE, FABRIC_POR_N};
   assign unused_sram_done = SRAM_INIT_DONE ^ USRAM_INIT_DONE;
`endif

   logic [SYNC_STAGES-1:0][NS-1:0] sync_q;
   logic [NS-1:0]                  sync_s;
   logic                           por_s;
   logic                           lock_s;
   logic                           init_ok;

   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign por_s  = sync_s[0];
   assign lock_s = sync_s[2];
`ifdef INIT_SEQ_SRAM_GATE_EN
   assign init_ok = sync_s[1] & sync_s[3] & sync_s[4];
`else
   assign init_ok = sync_s[1];
`endif

   state_t           state_q, state_d;
   logic [LCK_W-1:0] lck_q, lck_d;
   logic [REL_W-1:0] rel_q, rel_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             rst_n_q;
   logic             err_q;

   always_comb begin
      state_d = state_q;
      lck_d   = '0;
      rel_d   = '0;
      tmo_d   = '0;
      case (state_q)
         WAIT_POR: begin
            if (por_s) state_d = WAIT_INIT;
         end
         WAIT_INIT, WAIT_LOCK: begin
            tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
               state_d = ERROR;
            end else if (!por_s) begin
               state_d = WAIT_POR;
            end else if (state_q == WAIT_INIT) begin
               if (init_ok) state_d = WAIT_LOCK;
            end else if (lock_s) begin
               if (lck_q == LCK_LAST) begin
                  state_d = STRETCH;
                  tmo_d   = '0;
               end else begin
                  lck_d = lck_q + 1'b1;
               end
            end
         end
         STRETCH, RUN: begin
            // Any fall-back restarts the wait-phase timeout from zero (tmo_d default).
            if (!por_s) begin
               state_d = WAIT_POR;
            end else if (!init_ok) begin
               state_d = WAIT_INIT;
            end else if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (state_q == STRETCH) begin
               if (rel_q == REL_LAST) state_d = RUN;
               else                   rel_d   = rel_q + 1'b1;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = WAIT_POR;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!EXT_RST_N) begin
         state_q <= WAIT_POR;
         lck_q   <= '0;
         rel_q   <= '0;
         tmo_q   <= '0;
         rst_n_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lck_q   <= lck_d;
         rel_q   <= rel_d;
         tmo_q   <= tmo_d;
         rst_n_q <= (state_d == RUN);
         err_q   <= (state_d == ERROR);
      end
   end

   assign FABRIC_RESET_N = rst_n_q;
   assign INIT_STATE     = state_q;
   assign TIMEOUT_ERR    = err_q;

endmodule
